ckpt_seq_monitor: RTL and testbench
===================================

Name: ckpt_seq_monitor

Overview:
- Synthesizable checkpoint-sequence monitor for user-project bring-up, e.g. bfloat16 FMA firmware tests.
- Watches a WIDTH-bit probe word (GPIO/LA-driven status bus) for a programmed, ordered list of up to DEPTH checkpoint codes.
- Enforces a per-step cycle timeout and flags pass/fail in hardware, so silicon checks need no external waits or timers.
- Generalises the single start/pass code pair plus global timeout to N ordered codes, per-step timeouts and out-of-order detection.

Parameters:
WIDTH, 16, probe/checkpoint code width in bits
DEPTH, 8, max checkpoint entries (power of two, >=2)
TMO_W, 24, width of per-step timeout counter

Ports:
clock  in  1  system clock
resetb  in  1  asynchronous active-low reset
probe  in  WIDTH  observed checkpoint bus (e.g. mprj_io[31:16])
cfg_we  in  1  write expected code cfg_data to table[cfg_addr]
cfg_addr  in  $clog2(DEPTH)  table index
cfg_data  in  WIDTH  expected code
cfg_count  in  $clog2(DEPTH)+1  active entries (0..DEPTH), sampled on start
tmo_cycles  in  TMO_W  per-step timeout; 0 = disabled, sampled on start
start  in  1  one-cycle pulse: arm monitor
abort  in  1  return to IDLE, clear flags
busy  out  1  monitor armed
pass  out  1  sticky: all entries seen in order
fail  out  1  sticky: timeout or order violation
fail_code  out  2  00 none, 01 timeout, 10 out-of-order
step  out  $clog2(DEPTH)+1  index of next expected entry
step_cycles  out  TMO_W  cycles spent in current step (saturating)

Behaviour:
- Reset: busy, pass, fail, fail_code, step, step_cycles = 0. Probe pipeline and hit flags = 0. State = IDLE. Table contents undefined; no reset on table storage.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL hold until start or abort.
- IDLE/PASS/FAIL + start:
  - Latch cfg_count and tmo_cycles; clear step, step_cycles, pass, fail, fail_code.
  - cfg_count==0 -> PASS on the next edge.
  - Otherwise -> RUN, busy=1.
- Probe path: probe_q registered each edge (no reset dependence on probe). Match is evaluated on probe_q only.
- Debounce: an entry is "seen" when probe_q equals it on two consecutive samples (guards bus skew).
  - Probe stable from edge e0 -> step increments at edge e0+2.
- RUN:
  - Current entry seen: step++ and step_cycles=0. If the new step == count_lat, go to PASS (pass=1, busy=0) on that same edge.
  - Order violation: probe_q debounced-matches table[j] for step<j<count_lat and does not equal table[step] -> FAIL, fail_code=10. If codes are duplicated, the current entry wins.
  - Timeout: step_cycles increments each RUN cycle, saturating at all-ones. When tmo_lat!=0 and step_cycles==tmo_lat-1 with no advance that edge -> FAIL, fail_code=01.
  - If advance and timeout occur on the same edge, advance wins.
- abort has priority over everything: -> IDLE, all flags cleared. start while in RUN is ignored.
- cfg_we is honoured only outside RUN; writes during RUN are dropped.
- Table is written synchronously and is readable the cycle after the write.
- Asynchronous reset mid-run: immediate return to reset values, with no pass/fail pulse.

Optional Feature:
- Macro CKPT_MASK_EN.
- Defined:
  - Adds input cfg_mask[WIDTH-1:0], written alongside cfg_data.
  - Masked bits (mask=1) are don't-care for both current-entry match and order check.
  - Mask storage resets to 0.
- Undefined: port absent, exact compare. No mask storage is synthesized.

Decomposition:
- Package ckpt_pkg:
  - State enum (IDLE, RUN, PASS, FAIL).
  - fail_code constants FAIL_NONE/FAIL_TMO/FAIL_ORDER.
  - Width helper for the step index.
- Sub-module ckpt_table: DEPTH x WIDTH register file.
  - One write port; one read port at step.
  - Parallel "later-entry match" vector output (masked when CKPT_MASK_EN is defined).
- Top holds the FSM, probe pipeline, debounce and counters.

Test Plan:
- Program {AB60, AB61}, count=2, tmo=1000, start; drive AB60 then 10 cycles later AB61 -> step 0->1->2, pass=1 three edges after AB61 appears, fail=0.
- Same table, drive AB61 first held 2 cycles -> fail=1, fail_code=10, step=0, busy=0.
- tmo=50, never drive AB60 -> fail=1, fail_code=01 exactly 50 RUN cycles after start; step_cycles=49 at the fail edge.
- Single-cycle AB60 glitch between other values -> no advance. Held 2+ cycles -> advance.
- Assert resetb low mid-RUN at step=1 -> all outputs 0 immediately. After release, start with count=0 -> pass=1 next edge.
- With CKPT_MASK_EN: entry AB60, mask 000F, probe AB6C -> advances. Probe AB70 -> no advance.

Source files
------------

// File: rtl/ckpt_pkg.sv
// Shared types and helpers for the checkpoint-sequence monitor.
// Optional masked matching is enabled by defining CKPT_MASK_EN.
package ckpt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPass,
    StFail
  } state_e;

  localparam logic [1:0] FAIL_NONE  = 2'b00;
  localparam logic [1:0] FAIL_TMO   = 2'b01;
  localparam logic [1:0] FAIL_ORDER = 2'b10;

  // Step index must reach DEPTH itself, hence one bit more than the table address.
  function automatic int unsigned step_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ckpt_table.sv
// Checkpoint code table: one write port, a read/compare port at the current step and a
// parallel per-entry match vector. Per-entry don't-care masks exist only with CKPT_MASK_EN.
module ckpt_table
  import ckpt_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clock,
`ifdef CKPT_MASK_EN
  input  logic                        resetb,
  input  logic [WIDTH-1:0]            wmask,
`endif
  input  logic                        we,
  input  logic [$clog2(DEPTH)-1:0]    addr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [step_w(DEPTH)-1:0]    step,
  input  logic [step_w(DEPTH)-1:0]    count,
  input  logic [WIDTH-1:0]            probe_q,
  output logic                        cur_match,
  output logic [DEPTH-1:0]            match_vec,
  output logic [DEPTH-1:0]            later_vec
);

  localparam int unsigned SW = step_w(DEPTH);
  localparam int unsigned AW = SW - 1;

  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] care [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

`ifdef CKPT_MASK_EN
  logic [WIDTH-1:0] mask_mem [DEPTH];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) mask_mem[i] <= '0;
    end else if (we) begin
      mask_mem[addr] <= wmask;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) care[i] = ~mask_mem[i];
  end
`else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) care[i] = '1;
  end
`endif

  // later_vec flags entries strictly after the current step and inside the active count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = ((probe_q ^ mem[i]) & care[i]) == '0;
      later_vec[i] = match_vec[i] && (SW'(i) > step) && (SW'(i) < count);
    end
  end

  assign cur_match = ((probe_q ^ mem[step[AW-1:0]]) & care[step[AW-1:0]]) == '0;

endmodule

// File: rtl/ckpt_seq_monitor.sv
// Ordered checkpoint monitor: debounced probe matching, per-step timeout, order checking.
// Define CKPT_MASK_EN to add the cfg_mask port and per-entry don't-care bits.
module ckpt_seq_monitor
  import ckpt_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TMO_W = 24
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic [WIDTH-1:0]            probe,
  input  logic                        cfg_we,
  input  logic [$clog2(DEPTH)-1:0]    cfg_addr,
  input  logic [WIDTH-1:0]            cfg_data,
`ifdef CKPT_MASK_EN
  input  logic [WIDTH-1:0]            cfg_mask,
`endif
  input  logic [step_w(DEPTH)-1:0]    cfg_count,
  input  logic [TMO_W-1:0]            tmo_cycles,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        pass,
  output logic                        fail,
  output logic [1:0]                  fail_code,
  output logic [step_w(DEPTH)-1:0]    step,
  output logic [TMO_W-1:0]            step_cycles
);

  localparam int unsigned SW = step_w(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] probe_q;
  logic [DEPTH-1:0] hit_q, match_vec, later_vec;
  logic             cur_match, cur_seen, order_viol, tmo_hit;
  logic [SW-1:0]    step_q, step_d, count_q, count_d, step_inc;
  logic [TMO_W-1:0] cyc_q, cyc_d, tmo_q, tmo_d;
  logic [1:0]       fc_q, fc_d;

  ckpt_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clock     (clock),
`ifdef CKPT_MASK_EN
    .resetb    (resetb),
    .wmask     (cfg_mask),
`endif
    .we        (cfg_we && (state_q != StRun)),
    .addr      (cfg_addr),
    .wdata     (cfg_data),
    .step      (step_q),
    .count     (count_q),
    .probe_q   (probe_q),
    .cur_match (cur_match),
    .match_vec (match_vec),
    .later_vec (later_vec)
  );

  // An entry is seen when probe_q matched it on this sample and the previous one.
  assign cur_seen   = cur_match && hit_q[step_q[SW-2:0]];
  assign order_viol = (|(later_vec & hit_q)) && !cur_match;
  assign tmo_hit    = (tmo_q != '0) && (cyc_q == tmo_q - TMO_W'(1));
  assign step_inc   = step_q + SW'(1);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cyc_d   = cyc_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    fc_d    = fc_q;
    if (abort) begin
      state_d = StIdle;
      step_d  = '0;
      cyc_d   = '0;
      fc_d    = FAIL_NONE;
    end else begin
      unique case (state_q)
        StRun: begin
          if (cur_seen) begin
            step_d = step_inc;
            cyc_d  = '0;
            if (step_inc == count_q) state_d = StPass;
          end else if (order_viol) begin
            state_d = StFail;
            fc_d    = FAIL_ORDER;
          end else if (tmo_hit) begin
            state_d = StFail;
            fc_d    = FAIL_TMO;
          end else if (cyc_q != '1) begin
            cyc_d = cyc_q + TMO_W'(1);
          end
        end
        default: begin
          if (start) begin
            count_d = cfg_count;
            tmo_d   = tmo_cycles;
            step_d  = '0;
            cyc_d   = '0;
            fc_d    = FAIL_NONE;
            state_d = (cfg_count == '0) ? StPass : StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      step_q  <= '0;
      cyc_q   <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      fc_q    <= FAIL_NONE;
      probe_q <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cyc_q   <= cyc_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      fc_q    <= fc_d;
      probe_q <= probe;
      hit_q   <= match_vec;
    end
  end

  assign busy        = (state_q == StRun);
  assign pass        = (state_q == StPass);
  assign fail        = (state_q == StFail);
  assign fail_code   = fc_q;
  assign step        = step_q;
  assign step_cycles = cyc_q;

endmodule

// File: tb/tb_ckpt_seq_monitor.sv
// Scoreboard bench for ckpt_seq_monitor: directed scenarios plus randomized sequences
// checked against a behavioural model. Masked-match checks run when CKPT_MASK_EN is defined.
module tb_ckpt_seq_monitor;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO_W = 24;
  localparam int unsigned SW    = 4;

  logic             clock = 1'b0;
  logic             resetb = 1'b0;
  logic [WIDTH-1:0] probe = '0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic [WIDTH-1:0] cfg_mask = '0;
  logic [SW-1:0]    cfg_count = '0;
  logic [TMO_W-1:0] tmo_cycles = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, pass, fail;
  logic [1:0]       fail_code;
  logic [SW-1:0]    step;
  logic [TMO_W-1:0] step_cycles;

  ckpt_seq_monitor #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TMO_W (TMO_W)
  ) dut (
    .clock       (clock),
    .resetb      (resetb),
    .probe       (probe),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
`ifdef CKPT_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .cfg_count   (cfg_count),
    .tmo_cycles  (tmo_cycles),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .pass        (pass),
    .fail        (fail),
    .fail_code   (fail_code),
    .step        (step),
    .step_cycles (step_cycles)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       code;
    logic [SW-1:0]    step;
    logic [TMO_W-1:0] cyc;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: 0 idle, 1 running, 2 passed, 3 failed.
  int               m_st = 0, m_step = 0, m_cyc = 0, m_cnt = 0, m_tmo = 0, m_fc = 0;
  logic [WIDTH-1:0] m_tab [DEPTH];
  logic [WIDTH-1:0] m_msk [DEPTH];
  logic [WIDTH-1:0] p1 = '0, p2 = '0;

  function automatic bit eqm(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] m);
    return ((a ^ b) & ~m) == '0;
  endfunction

  function automatic bit seen(input int j);
    return eqm(p1, m_tab[j], m_msk[j]) && eqm(p2, m_tab[j], m_msk[j]);
  endfunction

  always @(posedge clock) begin
    obs_t e;
    bit   was_run;
    bit   later;
    if (!resetb) begin
      m_st = 0; m_step = 0; m_cyc = 0; m_fc = 0; m_cnt = 0; m_tmo = 0;
      p1 = '0; p2 = '0;
      for (int j = 0; j < DEPTH; j++) m_msk[j] = '0;
    end else begin
      was_run = (m_st == 1);
      if (abort) begin
        m_st = 0; m_step = 0; m_cyc = 0; m_fc = 0;
      end else if (m_st == 1) begin
        later = 1'b0;
        for (int j = m_step + 1; j < m_cnt; j++) if (seen(j)) later = 1'b1;
        if (seen(m_step)) begin
          m_step++;
          m_cyc = 0;
          if (m_step == m_cnt) m_st = 2;
        end else if (later && !eqm(p1, m_tab[m_step], m_msk[m_step])) begin
          m_st = 3; m_fc = 2;
        end else if (m_tmo != 0 && m_cyc == m_tmo - 1) begin
          m_st = 3; m_fc = 1;
        end else if (m_cyc < (1 << TMO_W) - 1) begin
          m_cyc++;
        end
      end else if (start) begin
        m_cnt = int'(cfg_count); m_tmo = int'(tmo_cycles);
        m_step = 0; m_cyc = 0; m_fc = 0;
        m_st = (m_cnt == 0) ? 2 : 1;
      end
      if (!was_run && cfg_we) begin
        m_tab[cfg_addr] = cfg_data;
`ifdef CKPT_MASK_EN
        m_msk[cfg_addr] = cfg_mask;
`endif
      end
      p2 = p1;
      p1 = probe;
    end
    e.busy = (m_st == 1);
    e.pass = (m_st == 2);
    e.fail = (m_st == 3);
    e.code = 2'(m_fc);
    e.step = SW'(m_step);
    e.cyc  = TMO_W'(m_cyc);
    exp_q.push_back(e);
  end

  // Monitor: one expected observation per clock edge, sampled 1 time unit later.
  always @(posedge clock) begin
    obs_t e;
    obs_t a;
    #1;
    a = '{busy: busy, pass: pass, fail: fail, code: fail_code, step: step, cyc: step_cycles};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty at %0t: nothing expected", $time);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs at %0t: got busy=%0b pass=%0b fail=%0b code=%0b step=%0d cyc=%0d, want busy=%0b pass=%0b fail=%0b code=%0b step=%0d cyc=%0d",
                 $time, a.busy, a.pass, a.fail, a.code, a.step, a.cyc,
                 e.busy, e.pass, e.fail, e.code, e.step, e.cyc);
      end
    end
  end

  task automatic chk_zero(input string tag);
    n_cmp++;
    if ({busy, pass, fail, fail_code, step, step_cycles} !== '0) begin
      n_bad++;
      $display("FAIL %s: got busy=%0b pass=%0b fail=%0b code=%0b step=%0d cyc=%0d, want all 0",
               tag, busy, pass, fail, fail_code, step, step_cycles);
    end
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d; cfg_mask = m;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic arm(input int cnt, input int tmo);
    cfg_count = SW'(cnt); tmo_cycles = TMO_W'(tmo); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic hold(input logic [WIDTH-1:0] v, input int n);
    probe = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
  endtask

  initial begin
    int hl;
    #1 chk_zero("reset_state");
    repeat (3) @(negedge clock);
    resetb = 1'b1;

    // Two-entry pass, then order violation, then timeout at 50 cycles.
    wr(0, 16'hAB60, '0); wr(1, 16'hAB61, '0);
    hold('0, 1);
    arm(2, 1000); hold('0, 3); hold(16'hAB60, 10); hold(16'hAB61, 5); hold('0, 2);
    arm(2, 1000); hold(16'hAB61, 3); hold('0, 3);
    arm(2, 50); hold('0, 55);

    // Single-cycle glitch must not advance; a held value must.
    arm(2, 0); hold(16'h1234, 3); hold(16'hAB60, 1); hold(16'h1234, 3);
    hold(16'hAB60, 3); hold(16'hAB61, 4); hold('0, 2);

    // Abort from run, then reset mid-run at step 1.
    arm(2, 0); hold(16'h5555, 3); do_abort(); hold('0, 2);
    arm(2, 0); hold(16'hAB60, 4);
    #2 resetb = 1'b0;
    #1 chk_zero("async_reset_mid_run");
    @(negedge clock); @(negedge clock);
    resetb = 1'b1;
    probe = '0;
    arm(0, 0); hold('0, 2);

`ifdef CKPT_MASK_EN
    wr(0, 16'hAB60, 16'h000F); wr(1, 16'h1111, '0);
    hold('0, 1);
    arm(2, 0); hold(16'hAB6C, 4); do_abort();
    arm(2, 0); hold(16'hAB70, 5); do_abort();
    hold('0, 2);
`endif

    // Randomized sequences; small code pool so duplicates and order hits occur.
    for (int it = 0; it < 60; it++) begin
      for (int j = 0; j < DEPTH; j++)
        wr(j, 16'hC000 + WIDTH'($urandom_range(0, 11)), WIDTH'($urandom_range(0, 3)));
      hold('0, 1);
      arm($urandom_range(0, 8), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 40));
      for (int k = 0; k < 90 && m_st == 1; k += hl) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: probe = m_tab[m_step % DEPTH];
          6, 7:             probe = m_tab[$urandom_range(0, DEPTH - 1)];
          default:          probe = 16'h0100 + WIDTH'($urandom_range(0, 255));
        endcase
        hl = $urandom_range(1, 3);
        for (int c = 0; c < hl; c++) begin
          abort  = ($urandom_range(0, 59) == 0);
          start  = (m_st == 1) && ($urandom_range(0, 19) == 0);
          cfg_we = (m_st == 1) && ($urandom_range(0, 9) == 0);
          cfg_addr = 3'($urandom_range(0, 7));
          cfg_data = WIDTH'($urandom);
          @(negedge clock);
          abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
        end
      end
      if (m_st == 1) do_abort();
      hold('0, 2);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
